// File: rtl/vert_cmd_sender.sv
// Host-side framer for the vertical motor CPLD link: one motion command becomes a 5-byte UART frame.
// Define VERT_CMD_STATUS_EN to build the status-byte decoder and the per-channel busy tracker.
module vert_cmd_sender #(
    parameter logic [7:0] TRAILER = 8'h00
) (
    input  logic        CLK_SE_AR,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_chan,
    input  logic [14:0] cmd_divider,
    input  logic [12:0] cmd_steps,
    output logic        bad_chan,
    output logic        frame_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [9:0]  chan_free
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GAP, ST_WAITB} tx_state_t;

    tx_state_t   state_r;
    logic [2:0]  idx_r;
    logic [31:0] word_r;
    logic [7:0]  tx_data_r;
    logic        tx_start_r;
    logic        bad_chan_r;
    logic        frame_done_r;

    logic [9:0]  chan_free_s;
    logic        chan_bad_s;
    logic        chan_ok_s;
    logic        accept_s;
    logic [31:0] word_s;

    function automatic logic [7:0] frame_byte(input logic [31:0] w, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = w[7:0];
            3'd1:    b = w[15:8];
            3'd2:    b = w[23:16];
            3'd3:    b = w[31:24];
            default: b = TRAILER;
        endcase
        return b;
    endfunction

    assign chan_bad_s = (cmd_chan > 4'd9);
    assign word_s     = {cmd_steps, cmd_divider, cmd_chan};

    // Out-of-range channels are always accepted so they can be flagged and dropped.
    always_comb begin
        chan_ok_s = 1'b1;
        if (chan_bad_s) begin
            chan_ok_s = 1'b1;
        end else begin
            chan_ok_s = chan_free_s[cmd_chan];
        end
    end

    assign cmd_ready = ~rst & (state_r == ST_IDLE) & chan_ok_s;
    assign accept_s  = cmd_valid & cmd_ready;

    // Transmit sequencer: LOAD pulses the start, GAP lets tx_busy rise, WAITB waits for it to drop.
    always_ff @(posedge CLK_SE_AR) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 3'd0;
            word_r       <= 32'h0000_0000;
            tx_data_r    <= 8'h00;
            tx_start_r   <= 1'b0;
            bad_chan_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            tx_start_r   <= 1'b0;
            bad_chan_r   <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idx_r <= 3'd0;
                    if (accept_s) begin
                        if (chan_bad_s) begin
                            bad_chan_r <= 1'b1;
                        end else begin
                            word_r     <= word_s;
                            tx_data_r  <= word_s[7:0];
                            tx_start_r <= 1'b1;
                            state_r    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD:  state_r <= ST_GAP;
                ST_GAP:   state_r <= ST_WAITB;
                ST_WAITB: begin
                    if (!tx_busy) begin
                        if (idx_r == 3'd4) begin
                            idx_r        <= 3'd0;
                            frame_done_r <= 1'b1;
                            state_r      <= ST_IDLE;
                        end else begin
                            idx_r      <= idx_r + 3'd1;
                            tx_data_r  <= frame_byte(word_r, idx_r + 3'd1);
                            tx_start_r <= 1'b1;
                            state_r    <= ST_LOAD;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_r;
    assign tx_start   = tx_start_r;
    assign bad_chan   = bad_chan_r;
    assign frame_done = frame_done_r;
    assign chan_free  = chan_free_s;

`ifdef VERT_CMD_STATUS_EN
    typedef enum logic [1:0] {CH_FREE = 2'd0, CH_SKIP = 2'd1, CH_PEND = 2'd2} ch_state_t;

    ch_state_t  chan_state_r [0:9];
    ch_state_t  chan_next_s  [0:9];
    logic [9:0] chan_free_r;
    logic [9:0] free_next_s;
    logic       rx_q_r;
    logic       rx_prev_r;
    logic [7:0] rx_byte_r;
    logic       good_s;
    logic       status_s;
    logic [9:0] hit_s;
    logic [9:0] flag_s;

    assign good_s   = accept_s & ~chan_bad_s;
    assign status_s = rx_q_r & ~rx_prev_r & (rx_byte_r[6:5] == 2'b00);
    assign hit_s    = status_s ? (rx_byte_r[7] ? 10'b11111_00000 : 10'b00000_11111) : 10'b00000_00000;
    assign flag_s   = {rx_byte_r[4:0], rx_byte_r[4:0]};

    // A SKIP channel ignores the first status byte, which may predate its frame; acceptance wins ties.
    always_comb begin
        for (int c = 0; c < 10; c++) begin
            chan_next_s[c] = chan_state_r[c];
            if (good_s && (cmd_chan == 4'(c))) begin
                chan_next_s[c] = CH_SKIP;
            end else if (hit_s[c]) begin
                case (chan_state_r[c])
                    CH_SKIP: chan_next_s[c] = CH_PEND;
                    CH_PEND: begin
                        if (flag_s[c]) begin
                            chan_next_s[c] = CH_PEND;
                        end else begin
                            chan_next_s[c] = CH_FREE;
                        end
                    end
                    CH_FREE: chan_next_s[c] = CH_FREE;
                    default: chan_next_s[c] = CH_FREE;
                endcase
            end else begin
                chan_next_s[c] = chan_state_r[c];
            end
            free_next_s[c] = (chan_next_s[c] == CH_FREE);
        end
    end

    // Status byte capture, rx_ready edge detection and tracker state.
    always_ff @(posedge CLK_SE_AR) begin
        if (rst) begin
            rx_q_r      <= 1'b0;
            rx_prev_r   <= 1'b0;
            rx_byte_r   <= 8'h00;
            chan_free_r <= 10'h3FF;
            for (int c = 0; c < 10; c++) begin
                chan_state_r[c] <= CH_FREE;
            end
        end else begin
            rx_q_r      <= rx_ready;
            rx_prev_r   <= rx_q_r;
            rx_byte_r   <= rx_data;
            chan_free_r <= free_next_s;
            for (int c = 0; c < 10; c++) begin
                chan_state_r[c] <= chan_next_s[c];
            end
        end
    end

    assign chan_free_s = chan_free_r;
`else
    logic unused_rx_s;
    assign unused_rx_s = ^{rx_data, rx_ready};
    assign chan_free_s = 10'h3FF;
`endif

endmodule

// File: tb/tb_vert_cmd_sender.sv
// Scoreboard bench for vert_cmd_sender: stimulus queues expected bytes, a monitor pops them on tx_start.
module tb_vert_cmd_sender;

`ifdef VERT_CMD_STATUS_EN
    localparam bit TRK = 1'b1;
`else
    localparam bit TRK = 1'b0;
`endif

    logic        CLK_SE_AR;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_chan;
    logic [14:0] cmd_divider;
    logic [12:0] cmd_steps;
    logic        bad_chan;
    logic        frame_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [9:0]  chan_free;

    vert_cmd_sender dut (
        .CLK_SE_AR   (CLK_SE_AR),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_chan    (cmd_chan),
        .cmd_divider (cmd_divider),
        .cmd_steps   (cmd_steps),
        .bad_chan    (bad_chan),
        .frame_done  (frame_done),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .chan_free   (chan_free)
    );

    int         n_total = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    int         busy_len = 2;
    bit         bp_mode = 1'b0;
    int         cyc = 0;
    int         last_start_cyc = 0;
    int         starts_seen = 0;
    int         bytes_in_frame = 0;
    int         frames_seen = 0;
    logic [7:0] last_exp = 8'h00;

    initial begin
        CLK_SE_AR = 1'b0;
        forever #5 CLK_SE_AR = ~CLK_SE_AR;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] exp_free(input logic [9:0] v);
        return TRK ? v : 10'h3FF;
    endfunction

    // Monitor: pops the scoreboard on every tx_start and checks data hold and frame length.
    initial begin
        forever begin
            @(negedge CLK_SE_AR);
            cyc++;
            if (rst) begin
                last_exp = 8'h00;
                bytes_in_frame = 0;
            end else begin
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_tx_start", 32'd1, 32'd0);
                    end else begin
                        last_exp = exp_q.pop_front();
                        check("tx_byte", tx_data, last_exp);
                    end
                    if (bp_mode && bytes_in_frame > 0)
                        check("bp_spacing_ge_500", 32'((cyc - last_start_cyc) >= 500), 32'd1);
                    last_start_cyc = cyc;
                    bytes_in_frame++;
                    starts_seen++;
                end else begin
                    check("tx_data_stable", tx_data, last_exp);
                end
                if (frame_done) begin
                    check("frame_len", bytes_in_frame, 32'd5);
                    bytes_in_frame = 0;
                    frames_seen++;
                end
            end
        end
    end

    // Transmitter model: busy for busy_len cycles after each start pulse.
    initial begin
        int cnt;
        cnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge CLK_SE_AR);
            if (tx_start === 1'b1) cnt = busy_len;
            else if (cnt > 0) cnt--;
            tx_busy = (cnt > 0);
        end
    end

    task automatic send_cmd(input logic [3:0] ch, input logic [14:0] dv, input logic [12:0] st,
                            input logic [39:0] eb, output int lat);
        bit ok;
        ok = 1'b0;
        lat = -1;
        @(posedge CLK_SE_AR); #1;
        cmd_chan = ch; cmd_divider = dv; cmd_steps = st; cmd_valid = 1'b1;
        if (ch <= 4'd9)
            for (int k = 0; k < 5; k++) exp_q.push_back(eb[39 - 8*k -: 8]);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK_SE_AR);
            if (cmd_ready) begin
                ok = 1'b1;
                lat = i;
                break;
            end
        end
        if (!ok) begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            cmd_chan = 4'hF;
            return;
        end
        @(posedge CLK_SE_AR); #1;
        cmd_valid = 1'b0;
        cmd_chan = 4'hF;
        @(negedge CLK_SE_AR);
        if (ch <= 4'd9) begin
            check("start_latency", tx_start, 32'd1);
        end else begin
            check("bad_chan_pulse", bad_chan, 32'd1);
            check("bad_chan_no_start", tx_start, 32'd0);
        end
    endtask

    task automatic wait_frame(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK_SE_AR);
            if (frame_done) begin
                check("ready_at_frame_done", cmd_ready, 32'd1);
                return;
            end
        end
        check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_status(input logic [7:0] b);
        @(posedge CLK_SE_AR); #1;
        rx_data = b;
        rx_ready = 1'b1;
        repeat (2) @(posedge CLK_SE_AR);
        #1 rx_ready = 1'b0;
        repeat (3) @(posedge CLK_SE_AR);
    endtask

    task automatic check_free(input string name, input logic [9:0] v);
        @(negedge CLK_SE_AR);
        check(name, chan_free, exp_free(v));
    endtask

    initial begin
        int lat;
        int base;
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        rst = 1'b1; cmd_valid = 1'b0; cmd_chan = 4'hF; cmd_divider = 15'h0; cmd_steps = 13'h0;
        rx_data = 8'h00; rx_ready = 1'b0;
        repeat (3) @(posedge CLK_SE_AR);
        @(negedge CLK_SE_AR);
        check("rst_cmd_ready", cmd_ready, 32'd0);
        check("rst_tx_start", tx_start, 32'd0);
        check("rst_tx_data", tx_data, 32'h00);
        check("rst_bad_chan", bad_chan, 32'd0);
        check("rst_frame_done", frame_done, 32'd0);
        check("rst_chan_free", chan_free, 32'h3FF);
        @(posedge CLK_SE_AR); #1 rst = 1'b0;

        // Frame encoding and gating on channel 3
        send_cmd(4'd3, 15'h1234, 13'h0ABC, 40'h43_23_E1_55_00, lat);
        wait_frame(200);
        check_free("free_after_ch3", 10'h3F7);
        send_status(8'h08);
        check_free("ch3_skip_to_pend", 10'h3F7);
        send_status(8'h08);
        check_free("ch3_pend_flag1", 10'h3F7);
        @(posedge CLK_SE_AR); #1 cmd_chan = 4'd3;
        @(negedge CLK_SE_AR);
        check("ch3_ready_held", cmd_ready, 32'(!TRK));
        send_status(8'h00);
        check_free("ch3_released", 10'h3FF);
        @(negedge CLK_SE_AR);
        check("ch3_ready_after_release", cmd_ready, 32'd1);
        send_cmd(4'd3, 15'h1234, 13'h0ABC, 40'h43_23_E1_55_00, lat);
        wait_frame(200);
        send_status(8'h00);
        send_status(8'h00);
        check_free("ch3_free_again", 10'h3FF);

        // Half select on channel 7
        send_cmd(4'd7, 15'h7FFF, 13'h1FFF, 40'hF7_FF_FF_FF_00, lat);
        wait_frame(200);
        check_free("free_after_ch7", 10'h37F);
        send_status(8'h80);
        check_free("ch7_skip_to_pend", 10'h37F);
        send_status(8'h00);
        check_free("ch7_other_half", 10'h37F);
        send_status(8'hA0);
        check_free("ch7_invalid_byte", 10'h37F);
        send_status(8'h80);
        check_free("ch7_released", 10'h3FF);

        // Bad channel
        send_cmd(4'd12, 15'h0001, 13'h0001, 40'h0, lat);
        check("bad_chan_accept_latency", lat, 32'd0);
        @(negedge CLK_SE_AR);
        check("bad_chan_one_cycle", bad_chan, 32'd0);

        // Back-pressure on channel 9
        busy_len = 500;
        bp_mode = 1'b1;
        base = starts_seen;
        send_cmd(4'd9, 15'h5A5A, 13'h0123, 40'hA9_A5_1D_09_00, lat);
        wait_frame(4000);
        check("bp_start_count", starts_seen - base, 32'd5);
        bp_mode = 1'b0;
        busy_len = 2;
        check_free("free_after_ch9", 10'h1FF);
        send_status(8'h80);
        send_status(8'h80);
        check_free("ch9_released", 10'h3FF);

        // Reset in the middle of a frame
        busy_len = 20;
        base = starts_seen;
        send_cmd(4'd0, 15'h0001, 13'h0001, 40'h10_00_08_00_00, lat);
        for (int i = 0; i < 500 && starts_seen < base + 3; i++) @(negedge CLK_SE_AR);
        check("mid_frame_three_starts", starts_seen - base, 32'd3);
        @(posedge CLK_SE_AR); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge CLK_SE_AR); #1 rst = 1'b0;
        repeat (60) @(posedge CLK_SE_AR);
        check("no_start_after_rst", starts_seen - base, 32'd3);
        check_free("free_after_rst", 10'h3FF);
        busy_len = 2;
        send_cmd(4'd0, 15'h0001, 13'h0001, 40'h10_00_08_00_00, lat);
        wait_frame(200);

        repeat (5) @(posedge CLK_SE_AR);
        check("queue_empty", exp_q.size(), 32'd0);
        check("frames_seen", frames_seen, 32'd5);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vert_cmd_sender.md
# vert_cmd_sender

Host-side command framer for the vertical motor CPLD link. It takes per-channel motion commands (channel, divider, step count) and serialises each one into the 5-byte UART frame the CPLD command parser expects, driving an `async_transmitter` byte by byte. It also decodes the CPLD's periodic status bytes from an `async_receiver` and keeps a per-channel free/busy view. That view gates new commands so no frame is sent to a channel whose previous command is still pending, because the CPLD would silently drop such a frame.

## Interface
- `TRAILER`, default 8'h00: value of frame byte 4; the CPLD parser ignores it.
- `CLK_SE_AR` input 1: system clock (24 MHz); the only clock.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted on the cycle where `cmd_valid & cmd_ready`.
- `cmd_chan` input 4: target channel, 0–9.
- `cmd_divider` input 15: step divider.
- `cmd_steps` input 13: steps to go.
- `bad_chan` output 1: one-cycle pulse when a command with `cmd_chan > 9` is accepted.
- `frame_done` output 1: one-cycle pulse when the last byte of a frame has been handed off.
- `tx_data` output 8: byte to the transmitter.
- `tx_start` output 1: one-cycle start pulse to the transmitter.
- `tx_busy` input 1: transmitter busy.
- `rx_data` input 8: status byte from the receiver.
- `rx_ready` input 1: receiver data-ready level; this block edge-detects it internally.
- `chan_free` output 10: bit c = 1 when channel c may accept a command.

## Operation
- **Frame word:** W = {`cmd_steps`[12:0], `cmd_divider`[14:0], `cmd_chan`[3:0]}, 32 bits, latched on acceptance.
- **Byte order:** byte0 = W[7:0], byte1 = W[15:8], byte2 = W[23:16], byte3 = W[31:24], byte4 = `TRAILER`.
  - Byte0 carries the channel in its low nibble and `cmd_divider`[3:0] in its high nibble.
- **`cmd_ready`:** equals (FSM in IDLE) & (`cmd_chan` > 9 | `chan_free`[`cmd_chan`]).
- **`cmd_chan` > 9:** the command is accepted, no frame is sent, and `bad_chan` pulses on the next cycle.
- **TX FSM states:** IDLE → LOAD → GAP → WAITB → (LOAD for the next byte | IDLE after byte 4).
  - LOAD: drive `tx_data` with byte[idx] and assert `tx_start` for exactly 1 cycle.
  - GAP: 1 cycle, `tx_busy` is not sampled.
  - WAITB: stay until `tx_busy` = 0.
  - `idx` counts 0..4 and resets to 0 in IDLE.
- **Per-channel tracker:** 2-bit state per channel: FREE, SKIP, PEND.
  - `chan_free`[c] = (state == FREE).
  - At frame acceptance for channel c: FREE → SKIP.
- **Status byte:** a valid byte has bits [6:5] = 00.
  - Bit 7 = half h: h = 0 covers channels 0–4, h = 1 covers channels 5–9.
  - Bits [4:0] = pending flags for channels 5h..5h+4.
  - A byte with bits [6:5] ≠ 00 is ignored.
- **Status update rules:** on the `rx_ready` rising edge with a valid byte, for each channel c in half h:
  - SKIP → PEND, and the flag is discarded, because this byte may have been built before the frame arrived.
  - PEND with flag 0 → FREE; PEND with flag 1 stays PEND.
  - FREE ignores the flag.
- **Simultaneous events:** if acceptance and a status byte for the same channel occur in the same cycle, acceptance wins and the channel goes to SKIP.

## Timing
- **Reset values:** `cmd_ready` = 0 during reset; `tx_start` = 0, `tx_data` = 8'h00, `bad_chan` = 0, `frame_done` = 0, `chan_free` = 10'h3FF.
  - Internal state: FSM in IDLE, all channels FREE, rx edge register = 0.
- **Reset mid-frame:** the frame is aborted with no further `tx_start`, and channel state is cleared to FREE.
- **Frame start:** acceptance at cycle T gives `tx_start` with byte0 at T+1.
- **Byte spacing:** next LOAD is one cycle after the first WAITB cycle that sees `tx_busy` = 0. Minimum byte-to-byte spacing is 3 cycles plus the transmitter busy time.
- **Frame end:** `frame_done` is asserted in the cycle after the WAITB that completes byte 4, and the FSM is in IDLE at that same cycle. `cmd_ready` can be 1 in that cycle.
- **Status update:** the rising edge is detected one cycle after `rx_ready` rises, and `chan_free` updates the following cycle.

## Configuration
- **Macro:** `VERT_CMD_STATUS_EN`.
- **Defined:** the status decoder and per-channel tracker are present as described above.
- **Undefined:** the tracker and decoder are removed.
  - `chan_free` is tied to 10'h3FF, and `rx_data`/`rx_ready` are unused.
  - `cmd_ready` = (FSM in IDLE).

## Test plan
- **Frame encoding:** chan=3, divider=15'h1234, steps=13'h0ABC → `tx_data` sequence 8'h43, 8'h23, 8'hE1, 8'h55, 8'h00; then `frame_done`; `chan_free`[3] = 0.
- **Gating and release:** after the frame to ch3, status 8'h08 → ch3 SKIP→PEND, still busy. Then status 8'h08 again → still busy. Then 8'h00 → `chan_free`[3] = 1; a new cmd to ch3 is held (`cmd_ready` = 0) until then.
- **Half select:** ch7 in PEND, status 8'h80 → `chan_free`[7] = 1. Status 8'h00 does not affect ch7. Status 8'hA0 is ignored.
- **Bad channel:** cmd_chan = 12 → accepted in 1 cycle, `bad_chan` pulse, no `tx_start`.
- **Back-pressure:** `tx_busy` held high for 500 cycles after each start → exactly 5 `tx_start` pulses, each ≥ 500 cycles apart, with `tx_data` stable during each.
- **Reset mid-frame:** `rst` pulse after byte 2 → no further `tx_start`, `chan_free` = 10'h3FF, next cmd starts again at byte0.
